// File: rtl/llr_frame_loader_if.sv
// Sample stream and RAM write port of llr_frame_loader.
// master: the loader (drives in_ready and the RAM bus); slave: upstream source / RAM side.
interface llr_frame_loader_if #(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned IN_WIDTH   = 8
);
  logic [IN_WIDTH-1:0]   in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic                  ram_we;
  logic                  ram_cs;

  modport master (
    input  in_data, in_valid,
    output in_ready, ram_address, ram_data_in, ram_we, ram_cs
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, ram_address, ram_data_in, ram_we, ram_cs
  );
endinterface

// File: rtl/llr_frame_loader.sv
// Loads one frame of channel samples as DATA_WIDTH-bit LLRs into RAM 0..len-1, then holds until acked.
// Optional macro LLR_SATURATE_EN: symmetric saturation instead of modular truncation, with sticky sat_flag.
module llr_frame_loader #(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned IN_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   frame_len_i,
  input  logic                  frame_ack_i,
  output logic                  frame_ready_o,
  output logic [ADDR_WIDTH:0]   words_loaded_o,
  output logic                  sat_flag_o,
  llr_frame_loader_if.master    bus
);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  we_q;
  logic                  sat_q;

  logic [DATA_WIDTH-1:0] conv_data;
  logic                  conv_clip;

`ifdef LLR_SATURATE_EN
  localparam logic signed [IN_WIDTH-1:0] SAT_HI = IN_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [IN_WIDTH-1:0] SAT_LO = -SAT_HI;

  // Symmetric clip: the most negative code is never produced.
  always_comb begin
    conv_clip = 1'b0;
    conv_data = bus.in_data[DATA_WIDTH-1:0];
    if ($signed(bus.in_data) > SAT_HI) begin
      conv_data = SAT_HI[DATA_WIDTH-1:0];
      conv_clip = 1'b1;
    end else if ($signed(bus.in_data) < SAT_LO) begin
      conv_data = SAT_LO[DATA_WIDTH-1:0];
      conv_clip = 1'b1;
    end
  end
`else
  logic unused_in_hi;
  assign unused_in_hi = ^bus.in_data[IN_WIDTH-1:DATA_WIDTH];
  assign conv_data    = bus.in_data[DATA_WIDTH-1:0];
  assign conv_clip    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i && (frame_len_i != '0)) begin
            len_q   <= (frame_len_i > MAX_LEN) ? MAX_LEN : frame_len_i;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          // in_ready is implied by LOAD, so in_valid alone marks an accept.
          if (bus.in_valid) begin
            we_q   <= 1'b1;
            addr_q <= cnt_q[ADDR_WIDTH-1:0];
            data_q <= conv_data;
            cnt_q  <= cnt_q + 1'b1;
            sat_q  <= sat_q | conv_clip;
            if (cnt_q == len_q - 1'b1) begin
              state_q <= READY;
            end
          end
        end
        READY: begin
          if (frame_ack_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == LOAD);
  assign bus.ram_address = addr_q;
  assign bus.ram_data_in = data_q;
  assign bus.ram_we      = we_q;
  assign bus.ram_cs      = we_q;
  assign frame_ready_o   = (state_q == READY);
  assign words_loaded_o  = cnt_q;
  assign sat_flag_o      = sat_q;

endmodule

// File: tb/tb_llr_frame_loader.sv
// Self-checking bench for llr_frame_loader: vector table, directed corner cases and random traffic
// compared every cycle against a frame-level reference model.
module tb_llr_frame_loader;
  localparam int DW = 5;
  localparam int AW = 8;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   frame_len;
  logic          frame_ack;
  logic          frame_ready;
  logic [AW:0]   words_loaded;
  logic          sat_flag;

  always #5 clk = ~clk;

  llr_frame_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IN_WIDTH(IW)) bus ();

  llr_frame_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IN_WIDTH(IW)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .frame_len_i    (frame_len),
    .frame_ack_i    (frame_ack),
    .frame_ready_o  (frame_ready),
    .words_loaded_o (words_loaded),
    .sat_flag_o     (sat_flag),
    .bus            (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: frame phase (0 idle, 1 loading, 2 holding), accepted count, pending write.
  int m_mode, m_len, m_cnt, m_addr, m_data, m_we, m_sat;
  int wr_count [256];

  typedef struct {
    logic st;   int len; logic vld; int din; logic ack;
    logic e_we; int e_addr; int e_data; logic e_inrdy; logic e_frdy; int e_words;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int conv_ref(input int x, output int clip);
    int v;
    v    = x;
    clip = 0;
`ifdef LLR_SATURATE_EN
    if (v > 15)  begin v = 15;  clip = 1; end
    if (v < -15) begin v = -15; clip = 1; end
`endif
    return v & 31;
  endfunction

  task automatic model_update();
    int c, x;
    if (rst) begin
      m_mode = 0; m_len = 0; m_cnt = 0; m_addr = 0; m_data = 0; m_we = 0; m_sat = 0;
    end else begin
      m_we = 0;
      if (m_mode == 0) begin
        if (start && frame_len != 0) begin
          m_len  = (int'(frame_len) > 256) ? 256 : int'(frame_len);
          m_cnt  = 0;
          m_sat  = 0;
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (bus.in_valid) begin
          x      = int'($signed(bus.in_data));
          m_data = conv_ref(x, c);
          m_addr = m_cnt % 256;
          m_we   = 1;
          m_sat  = m_sat | c;
          m_cnt  = m_cnt + 1;
          if (m_cnt == m_len) m_mode = 2;
        end
      end else begin
        if (frame_ack) m_mode = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("in_ready", int'(bus.in_ready), int'(m_mode == 1));
    chk("frame_ready", int'(frame_ready), int'(m_mode == 2));
    chk("ram_we", int'(bus.ram_we), m_we);
    chk("ram_cs", int'(bus.ram_cs), m_we);
    chk("ram_address", int'(bus.ram_address), m_addr);
    chk("ram_data_in", int'(bus.ram_data_in), m_data);
    chk("words_loaded", int'(words_loaded), m_cnt);
    chk("sat_flag", int'(sat_flag), m_sat);
    if (bus.ram_we) wr_count[bus.ram_address]++;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    start = 1'b0; frame_len = '0; frame_ack = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
  endtask

  task automatic clear_log();
    for (int i = 0; i < 256; i++) wr_count[i] = 0;
  endtask

  task automatic begin_frame(input int len);
    idle_inputs();
    start = 1'b1; frame_len = (AW+1)'(len);
    step();
    idle_inputs();
  endtask

  task automatic ack_frame();
    idle_inputs();
    frame_ack = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic feed_until_ready(input int cap, input bit toggle);
    int n;
    n = 0;
    while (m_mode == 1 && n < cap) begin
      bus.in_valid = toggle ? ((n % 2) == 0) : 1'b1;
      bus.in_data  = IW'($urandom);
      step();
      n++;
    end
    idle_inputs();
    chk("ready_within_budget", int'(m_mode == 2), 1);
  endtask

  initial begin
    int cnt_ones;
    int sat_in [4];
    int sat_exp [4];

    tbl[0] = '{1, 4, 0, 0, 0,  0, 0, 0,  1, 0, 0};
    tbl[1] = '{0, 0, 1, 3, 0,  1, 0, 3,  1, 0, 1};
    tbl[2] = '{0, 0, 1, -2, 0, 1, 1, 30, 1, 0, 2};
    tbl[3] = '{0, 0, 1, 7, 0,  1, 2, 7,  1, 0, 3};
    tbl[4] = '{0, 0, 1, 0, 0,  1, 3, 0,  0, 1, 4};
    tbl[5] = '{0, 0, 0, 0, 0,  0, 3, 0,  0, 1, 4};
    tbl[6] = '{0, 0, 0, 0, 1,  0, 3, 0,  0, 0, 4};

    sat_in = '{100, -100, -16, 15};
`ifdef LLR_SATURATE_EN
    sat_exp = '{15, 17, 17, 15};
`else
    sat_exp = '{4, 28, 16, 15};
`endif

    clear_log();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Four-sample frame from the vector table.
    for (int i = 0; i < 7; i++) begin
      start = tbl[i].st; frame_len = (AW+1)'(tbl[i].len);
      bus.in_valid = tbl[i].vld; bus.in_data = IW'(tbl[i].din);
      frame_ack = tbl[i].ack;
      step();
      chk("tbl_we", int'(bus.ram_we), int'(tbl[i].e_we));
      chk("tbl_addr", int'(bus.ram_address), tbl[i].e_addr);
      chk("tbl_data", int'(bus.ram_data_in), tbl[i].e_data);
      chk("tbl_in_ready", int'(bus.in_ready), int'(tbl[i].e_inrdy));
      chk("tbl_frame_ready", int'(frame_ready), int'(tbl[i].e_frdy));
      chk("tbl_words", int'(words_loaded), tbl[i].e_words);
    end
    idle_inputs();

    // Full-depth frame with gapped valid: each address exactly once.
    clear_log();
    begin_frame(256);
    feed_until_ready(1000, 1'b1);
    cnt_ones = 0;
    for (int a = 0; a < 256; a++) if (wr_count[a] == 1) cnt_ones++;
    chk("full_frame_each_addr_once", cnt_ones, 256);
    chk("full_frame_words", int'(words_loaded), 256);

    // Holding: valid and start must not disturb anything.
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = IW'($urandom);
      start = 1'b1; frame_len = 9'd5;
      step();
    end
    // start together with ack only acknowledges.
    idle_inputs();
    start = 1'b1; frame_len = 9'd5; frame_ack = 1'b1;
    step();
    chk("ack_returns_idle", int'(frame_ready), 0);
    idle_inputs();
    step();
    chk("start_with_ack_ignored", int'(bus.in_ready), 0);

    // Reset after 10 of 20 accepts.
    begin_frame(20);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.in_data = IW'($urandom);
      step();
    end
    clear_log();
    rst = 1'b1;
    step();
    chk("rst_words", int'(words_loaded), 0);
    chk("rst_we", int'(bus.ram_we), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    idle_inputs();
    chk("no_writes_after_rst", wr_count[10] + wr_count[11], 0);
    begin_frame(2);
    bus.in_valid = 1'b1; bus.in_data = 8'd9;
    step();
    chk("post_rst_addr0", int'(bus.ram_address), 0);
    bus.in_data = 8'd10;
    step();
    chk("post_rst_addr1", int'(bus.ram_address), 1);
    idle_inputs();
    ack_frame();

    // Zero-length start is ignored.
    clear_log();
    idle_inputs();
    start = 1'b1; frame_len = '0;
    bus.in_valid = 1'b1;
    step();
    step();
    idle_inputs();
    chk("len0_in_ready", int'(bus.in_ready), 0);

    // Over-length request is clamped.
    clear_log();
    begin_frame(300);
    feed_until_ready(1000, 1'b0);
    cnt_ones = 0;
    for (int a = 0; a < 256; a++) cnt_ones += wr_count[a];
    chk("len300_write_total", cnt_ones, 256);
    ack_frame();

    // Conversion corner values.
    begin_frame(4);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = IW'(sat_in[i]);
      step();
      chk("conv_value", int'(bus.ram_data_in), sat_exp[i]);
    end
    idle_inputs();
`ifdef LLR_SATURATE_EN
    chk("conv_sat_flag", int'(sat_flag), 1);
`else
    chk("conv_sat_flag", int'(sat_flag), 0);
`endif
    ack_frame();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      start        = ($urandom_range(0, 5) == 0);
      frame_len    = ($urandom_range(0, 19) == 0) ? (AW+1)'($urandom_range(0, 300))
                                                  : (AW+1)'($urandom_range(0, 24));
      frame_ack    = ($urandom_range(0, 4) == 0);
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.in_data  = IW'($urandom);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/llr_frame_loader.md
Name: llr_frame_loader

Overview:
- Upstream stage of the external LLR RAM (256 x 5-bit, single-port, shared cs/we write interface).
- Accepts channel LLR samples on a valid/ready stream, converts them to 5-bit signed LLRs, and writes one frame into RAM addresses 0..len-1.
- Then raises frame_ready and holds the RAM idle until the decoder acknowledges the frame.

Parameters:
- DATA_WIDTH, 5, stored LLR width (signed two's complement).
- ADDR_WIDTH, 8, RAM address width; maximum frame is 2^ADDR_WIDTH words.
- IN_WIDTH, 8, incoming channel sample width (signed two's complement); must be >= DATA_WIDTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin loading a frame.
- frame_len  input  ADDR_WIDTH+1  number of LLRs in the frame; sampled when start is accepted.
- in_data  input  IN_WIDTH  channel sample.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- ram_address  output  ADDR_WIDTH  RAM write address.
- ram_data_in  output  DATA_WIDTH  converted LLR.
- ram_we  output  1  RAM write enable.
- ram_cs  output  1  RAM chip select; asserted together with ram_we.
- frame_ready  output  1  complete frame is resident in RAM.
- frame_ack  input  1  decoder has consumed the frame.
- words_loaded  output  ADDR_WIDTH+1  LLRs accepted in the current frame.
- sat_flag  output  1  sticky per frame; at least one sample saturated (see Optional Feature).

Behaviour:
- Reset values: state IDLE; in_ready, ram_we, ram_cs, frame_ready and sat_flag are 0; ram_address, ram_data_in and words_loaded are 0.
- States: IDLE, LOAD, READY.
- in_ready is 1 exactly when state == LOAD. It is decoded from the state register only, never from in_valid.
- IDLE:
  - start=1 with frame_len in 1..2^ADDR_WIDTH: latch len, clear words_loaded and sat_flag, go to LOAD.
  - frame_len > 2^ADDR_WIDTH is clamped to 2^ADDR_WIDTH.
  - frame_len == 0: start is ignored and the state stays IDLE.
- LOAD, on each cycle with in_valid & in_ready (an accept):
  - Next cycle: ram_we = ram_cs = 1, ram_address = words_loaded (pre-increment value), ram_data_in = conv(in_data). Write latency is therefore 1 cycle after accept.
  - words_loaded increments by 1.
  - Cycles without an accept drive ram_we = ram_cs = 0 on the following cycle. ram_address and ram_data_in hold their last values.
- Last accept (words_loaded == len-1):
  - Next state is READY, so in_ready is 0 from the following cycle.
  - The final write issues in the first READY cycle, and frame_ready rises in that same cycle.
- Address wrap: ram_address is the low ADDR_WIDTH bits of the count. len = 2^ADDR_WIDTH writes addresses 0..255 with no wrap and no overrun.
- READY:
  - frame_ready = 1 and in_ready = 0; no RAM writes after the final one.
  - frame_ack = 1 → IDLE next cycle, frame_ready = 0. words_loaded and sat_flag hold until the next accepted start.
  - frame_ack while in IDLE or LOAD is ignored.
- start is ignored in LOAD and READY. The same-cycle combination start & frame_ack in READY only acknowledges the frame; a new start must come in IDLE.
- rst mid-frame: the partial frame is abandoned, all outputs take their reset values next cycle, and no further RAM writes occur. Stale RAM contents are not cleared.
- conv() default: take the low DATA_WIDTH bits of in_data (modular wrap); sat_flag stays 0.

Optional Feature:
- Macro: LLR_SATURATE_EN.
- Defined: conv() saturates the signed in_data symmetrically to [-(2^(DATA_WIDTH-1)-1), +(2^(DATA_WIDTH-1)-1)], i.e. -15..+15. The value -16 is never written. Any sample clipped, including an input of exactly -16, sets sticky sat_flag at the accept+1 cycle.
- Undefined: modular truncation as above; sat_flag is constant 0 and the port remains present.

Test Plan:
- Reset, then start with frame_len=4 and in_data 3, -2, 7, 0 streamed with in_valid held high → writes at addresses 0..3 on the cycles after each accept, with data 00011, 11110, 00111, 00000. frame_ready rises with the 4th write; in_ready is low from that cycle on.
- frame_len=256 with in_valid toggling 1/0 → exactly 256 writes at addresses 0..255, none repeated. Gaps give ram_we=0. words_loaded=256 in READY.
- In READY: in_valid held 1 and start pulsed → no writes and no state change. Then frame_ack=1 → IDLE next cycle, frame_ready=0.
- rst asserted after 10 of 20 accepts → next cycle all outputs are at reset values and there are no further writes. A new start with frame_len=2 writes addresses 0 and 1.
- start with frame_len=0 → stays IDLE, in_ready=0, no writes. start with frame_len=300 → exactly 256 writes.
- With LLR_SATURATE_EN: in_data 100, -100, -16, 15 → writes 01111, 10001, 10001, 01111 and sat_flag=1. Without the macro, the same input writes 00100, 11100, 10000, 01111 and sat_flag=0.
